// File: rtl/rijndael_pkg.sv
// Shared constants and helpers for the Rijndael ShiftRows datapath:
// state geometry, row rotation offsets and the byte-index map used by
// every module that reorders state bytes.
package rijndael_pkg;

   // A Rijndael state always has four rows; only the column count varies.
   localparam int ROWS = 4;

   // Column counts the unit supports: 128-, 192- and 256-bit blocks.
   function automatic bit nb_is_legal(input int nb);
      return (nb == 4) || (nb == 6) || (nb == 8);
   endfunction

   // Left-rotation applied to row r. The 256-bit block widens the
   // rotation of rows 2 and 3 by one column so that no two rows share a
   // diffusion pattern; narrower blocks rotate row r by r.
   function automatic int rot_off(input int nb, input int r);
      if ((nb == 8) && (r >= 2)) begin
         return r + 1;
      end
      return r;
   endfunction

   // Byte position inside the column-major state: byte 0 is the most
   // significant byte of the bus, and each column is four consecutive bytes.
   function automatic int byte_idx(input int r, input int c);
      return (ROWS * c) + r;
   endfunction

endpackage

// File: rtl/rijndael_shift_rows_comb.sv
// Purely combinational ShiftRows / InvShiftRows byte permutation.
// encrypt = 1 rotates every row left by its offset, encrypt = 0 rotates it
// right by the same amount. All byte positions are elaboration constants,
// so the result is one 2:1 byte mux per state byte and nothing else.
module rijndael_shift_rows_comb
   import rijndael_pkg::*;
#(
   parameter int NB = 4
) (
   input  logic [32*NB-1:0] data,
   input  logic             encrypt,
   output logic [32*NB-1:0] result
);

   localparam int W = 32 * NB;

   for (genvar c = 0; c < NB; c++) begin : g_col
      for (genvar r = 0; r < ROWS; r++) begin : g_row
         localparam int OFF = rot_off(NB, r);
         localparam int DST = byte_idx(r, c);
         // Forward rotation reads from OFF columns to the right; the
         // inverse reads from OFF columns to the left, wrapping at NB.
         localparam int FWD = byte_idx(r, (c + OFF) % NB);
         localparam int INV = byte_idx(r, (c - OFF + NB) % NB);

         assign result[W-1-8*DST -: 8] = encrypt ? data[W-1-8*FWD -: 8]
                                                 : data[W-1-8*INV -: 8];
      end
   end

endmodule

// File: rtl/rijndael_shift_rows_pipe.sv
// Pipelined Rijndael ShiftRows / InvShiftRows stage with valid/ready
// handshake, placed between SubBytes and MixColumns in the round datapath.
//
// The permutation is evaluated in front of stage 1; further stages are
// plain delay. Every stage is a one-entry skid-free register whose ready
// is "empty or draining", so bubbles collapse and back-pressure from the
// consumer ripples straight through to o_Ready.
//
// Build option: define SHIFTROW_SELFCHECK_EN to carry the original input
// and direction alongside each word and check, at the output, that the
// inverse permutation of o_Data reproduces it. A mismatch on a valid
// output sets the sticky o_Err. Without the macro o_Err is tied to 0 and
// no sideband logic exists.
module rijndael_shift_rows_pipe
   import rijndael_pkg::*;
#(
   parameter  int NB      = 4,
   parameter  int LATENCY = 1,
   localparam int W       = 32 * NB
) (
   input  logic         i_Clk,
   input  logic         i_Rst,
   input  logic         i_Valid,
   output logic         o_Ready,
   input  logic [W-1:0] i_Data,
   input  logic         i_fEncrypt,
   output logic         o_Valid,
   input  logic         i_Ready,
   output logic [W-1:0] o_Data,
   output logic         o_Err
);

   if (!nb_is_legal(NB)) begin : g_bad_nb
      $fatal(1, "rijndael_shift_rows_pipe: NB must be 4, 6 or 8");
   end

   if ((LATENCY < 1) || (LATENCY > 3)) begin : g_bad_latency
      $fatal(1, "rijndael_shift_rows_pipe: LATENCY must be 1..3");
   end

   // Permuted input word, ready to be captured by stage 1.
   logic [W-1:0] perm_data;

   // Stage registers; index 0 is stage 1 and index LATENCY-1 drives o_Data.
   logic [LATENCY-1:0]        stage_valid;
   logic [LATENCY-1:0][W-1:0] stage_data;
   logic [LATENCY-1:0]        stage_ready;

   // Chains view the pipe as LATENCY+1 taps: tap 0 is the upstream input,
   // tap s+1 is the output of stage s, tap LATENCY is the module output.
   // Stage s therefore always loads from tap s.
   logic [LATENCY:0]          chain_valid;
   logic [LATENCY:0][W-1:0]   chain_data;

   rijndael_shift_rows_comb #(
      .NB      (NB)
   ) u_perm (
      .data    (i_Data),
      .encrypt (i_fEncrypt),
      .result  (perm_data)
   );

   assign chain_valid = {stage_valid, i_Valid};
   assign chain_data  = {stage_data, perm_data};

   assign o_Valid = chain_valid[LATENCY];
   assign o_Data  = chain_data[LATENCY];
   assign o_Ready = stage_ready[0];

   // Ready ripples backwards from the consumer: a stage may load when it
   // is empty or when its current word is leaving this cycle.
   always_comb begin
      logic ready_acc;
      stage_ready = '0;
      ready_acc   = i_Ready;
      for (int s = LATENCY - 1; s >= 0; s--) begin
         ready_acc      = !stage_valid[s] || ready_acc;
         stage_ready[s] = ready_acc;
      end
   end

   // Pipeline advance: each stage that may load takes its upstream tap.
   // A full stage that emits and accepts in the same cycle keeps valid=1.
   always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
         // NOTE: the data registers are cleared as well because o_Data must
         // read zero after reset; these are ordinary flops, not a RAM.
         stage_valid <= '0;
         stage_data  <= '0;
      end else begin
         for (int s = 0; s < LATENCY; s++) begin
            if (stage_ready[s]) begin
               // NOTE: non-blocking updates make every stage sample its
               // neighbour's pre-edge value, so the loop shifts instead of
               // letting one word fall through several stages in one cycle.
               stage_valid[s] <= chain_valid[s];
               // Payload only moves with a real word, so idle bubbles
               // leave the data registers untouched.
               if (chain_valid[s]) begin
                  stage_data[s] <= chain_data[s];
               end
            end
         end
      end
   end

`ifdef SHIFTROW_SELFCHECK_EN
   // Sideband carried next to each word: the unpermuted input and the
   // direction it was permuted in.
   logic [LATENCY-1:0][W-1:0] stage_orig;
   logic [LATENCY-1:0]        stage_enc;
   logic [LATENCY:0][W-1:0]   chain_orig;
   logic [LATENCY:0]          chain_enc;
   logic [W-1:0]              restored;
   logic                      err_q;

   assign chain_orig = {stage_orig, i_Data};
   assign chain_enc  = {stage_enc, i_fEncrypt};

   // Undo the permutation at the output: run the opposite direction on
   // o_Data and expect the carried original back.
   rijndael_shift_rows_comb #(
      .NB      (NB)
   ) u_check (
      .data    (o_Data),
      .encrypt (!chain_enc[LATENCY]),
      .result  (restored)
   );

   // Sideband registers follow exactly the same load rule as the datapath.
   always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
         stage_orig <= '0;
         stage_enc  <= '0;
      end else begin
         for (int s = 0; s < LATENCY; s++) begin
            if (stage_ready[s] && chain_valid[s]) begin
               stage_orig[s] <= chain_orig[s];
               stage_enc[s]  <= chain_enc[s];
            end
         end
      end
   end

   // Sticky error: any valid output whose inverse differs from the carried
   // input latches o_Err until the next reset.
   always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
         err_q <= 1'b0;
      end else if (o_Valid && (restored != chain_orig[LATENCY])) begin
         err_q <= 1'b1;
      end
   end

   assign o_Err = err_q;
`else
   assign o_Err = 1'b0;
`endif

endmodule

// File: tb/tb_rijndael_shift_rows_pipe.sv
// Self-checking bench for rijndael_shift_rows_pipe.
// Two instances: A (NB=4, LATENCY=1) and B (NB=8, LATENCY=3). Each has a
// scoreboard fed by a matrix-based ShiftRows model; one compare process per
// instance checks every valid output, stall stability, and reset state.
module tb_rijndael_shift_rows_pipe;

   localparam int NB_A  = 4;
   localparam int LAT_A = 1;
   localparam int W_A   = 32 * NB_A;
   localparam int NB_B  = 8;
   localparam int LAT_B = 3;
   localparam int W_B   = 32 * NB_B;

   localparam logic [127:0] FIPS_IN  = 128'hd42711ae_e0bf98f1_b8b45de5_1e415230;
   localparam logic [127:0] FIPS_OUT = 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;
   logic rst_q = 1'b0;

   logic           a_valid, a_oready, a_enc, a_ovalid, a_iready, a_err;
   logic [W_A-1:0] a_data, a_odata;
   logic           b_valid, b_oready, b_enc, b_ovalid, b_iready, b_err;
   logic [W_B-1:0] b_data, b_odata;

   int tests_run    = 0;
   int tests_failed = 0;

   logic [255:0] q_a[$];
   logic [255:0] q_b[$];
   int a_in_cnt = 0, a_out_cnt = 0, b_in_cnt = 0, b_out_cnt = 0;
   bit a_chk_en = 1'b1;
   bit a_stall = 1'b0, b_stall = 1'b0;
   logic [W_A-1:0] a_prev_data;
   logic [W_B-1:0] b_prev_data;

   rijndael_shift_rows_pipe #(
      .NB         (NB_A),
      .LATENCY    (LAT_A)
   ) dut_a (
      .i_Clk      (clk),
      .i_Rst      (rst),
      .i_Valid    (a_valid),
      .o_Ready    (a_oready),
      .i_Data     (a_data),
      .i_fEncrypt (a_enc),
      .o_Valid    (a_ovalid),
      .i_Ready    (a_iready),
      .o_Data     (a_odata),
      .o_Err      (a_err)
   );

   rijndael_shift_rows_pipe #(
      .NB         (NB_B),
      .LATENCY    (LAT_B)
   ) dut_b (
      .i_Clk      (clk),
      .i_Rst      (rst),
      .i_Valid    (b_valid),
      .o_Ready    (b_oready),
      .i_Data     (b_data),
      .i_fEncrypt (b_enc),
      .o_Valid    (b_ovalid),
      .i_Ready    (b_iready),
      .o_Data     (b_odata),
      .o_Err      (b_err)
   );

   task automatic check(input string name, input logic [255:0] actual, input logic [255:0] expected);
      tests_run++;
      if (actual !== expected) begin
         tests_failed++;
         $display("FAIL %s: got %0h, want %0h", name, actual, expected);
      end
   endtask

   task automatic fail_now(input string name, input string what);
      tests_run++;
      tests_failed++;
      $display("FAIL %s: %s", name, what);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference model: unpack into a 4 x nb byte matrix, rotate each row,
   // repack. Data is right-aligned in the lower 32*nb bits.
   function automatic logic [255:0] model_shift(input logic [255:0] din, input int nb, input bit enc);
      logic [7:0]   st [4][8];
      int           offs [4];
      logic [255:0] dout;
      int           w;
      int           src;
      w    = 32 * nb;
      dout = '0;
      if (nb == 8) offs = '{0, 1, 3, 4};
      else         offs = '{0, 1, 2, 3};
      for (int c = 0; c < nb; c++)
         for (int r = 0; r < 4; r++)
            st[r][c] = din[w-1-8*(4*c+r) -: 8];
      for (int c = 0; c < nb; c++)
         for (int r = 0; r < 4; r++) begin
            src = enc ? (c + offs[r]) % nb : (c - offs[r] + nb) % nb;
            dout[w-1-8*(4*c+r) -: 8] = st[r][src];
         end
      return dout;
   endfunction

   function automatic logic [255:0] ascending(input int nb);
      logic [255:0] v;
      v = '0;
      for (int k = 0; k < 4 * nb; k++) v[32*nb-1-8*k -: 8] = 8'(k);
      return v;
   endfunction

   function automatic logic [255:0] rand256();
      logic [255:0] v;
      v = '0;
      for (int i = 0; i < 8; i++) v = {v[223:0], 32'($urandom)};
      return v;
   endfunction

   always @(posedge clk) rst_q <= rst;

   // Compare process for instance A.
   always @(negedge clk) begin
      if (rst_q) begin
         check("a_rst_valid", a_ovalid, 0);
         check("a_rst_data", a_odata, 0);
         check("a_rst_err", a_err, 0);
      end
      if (rst) begin
         q_a.delete();
         a_stall = 1'b0;
      end else begin
         if (a_stall && a_chk_en) begin
            check("a_stall_valid", a_ovalid, 1);
            check("a_stall_data", a_odata, a_prev_data);
         end
         if (a_ovalid) begin
            if (q_a.size() == 0) begin
               fail_now("a_spurious_out", $sformatf("got %0h, want no output", a_odata));
            end else begin
               if (a_chk_en) check("a_out", a_odata, q_a[0]);
               if (a_iready) begin
                  void'(q_a.pop_front());
                  a_out_cnt++;
               end
            end
         end
         if (a_valid && a_oready) begin
            q_a.push_back(model_shift(a_data, NB_A, a_enc));
            a_in_cnt++;
         end
         a_stall     = a_ovalid && !a_iready;
         a_prev_data = a_odata;
      end
   end

   // Compare process for instance B.
   always @(negedge clk) begin
      if (rst_q) begin
         check("b_rst_valid", b_ovalid, 0);
         check("b_rst_data", b_odata, 0);
         check("b_rst_err", b_err, 0);
      end
      if (rst) begin
         q_b.delete();
         b_stall = 1'b0;
      end else begin
         if (b_stall) begin
            check("b_stall_valid", b_ovalid, 1);
            check("b_stall_data", b_odata, b_prev_data);
         end
         if (b_ovalid) begin
            if (q_b.size() == 0) begin
               fail_now("b_spurious_out", $sformatf("got %0h, want no output", b_odata));
            end else begin
               check("b_out", b_odata, q_b[0]);
               if (b_iready) begin
                  void'(q_b.pop_front());
                  b_out_cnt++;
               end
            end
         end
         if (b_valid && b_oready) begin
            q_b.push_back(model_shift(b_data, NB_B, b_enc));
            b_in_cnt++;
         end
         b_stall     = b_ovalid && !b_iready;
         b_prev_data = b_odata;
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [255:0] asc8, asc6, m, r;
      int           cycles, base_in, base_out;

      rst = 1'b1;
      a_valid = 1'b0; a_data = '0; a_enc = 1'b0; a_iready = 1'b0;
      b_valid = 1'b0; b_data = '0; b_enc = 1'b0; b_iready = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_a_ready", a_oready, 1);
      check("rst_b_ready", b_oready, 1);
      check("rst_a_valid", a_ovalid, 0);
      check("rst_b_data", b_odata, 0);

      // Pin the model with hand-derived results.
      check("model_fips_enc", model_shift(FIPS_IN, 4, 1'b1), FIPS_OUT);
      check("model_fips_dec", model_shift(FIPS_OUT, 4, 1'b0), FIPS_IN);
      asc8 = ascending(8);
      m = model_shift(asc8, 8, 1'b1);
      check("model_nb8_col0", m[255 -: 32], 32'h00050e13);
      asc6 = ascending(6);
      m = model_shift(asc6, 6, 1'b1);
      check("model_nb6_col0", m[191 -: 32], 32'h00050a0f);

      // Test 1: NB=4 encrypt, one-cycle latency.
      tick();
      a_iready = 1'b1; a_valid = 1'b1; a_enc = 1'b1; a_data = FIPS_IN;
      tick();
      a_valid = 1'b0;
      @(negedge clk);
      check("t1_valid", a_ovalid, 1);
      check("t1_data", a_odata, FIPS_OUT);

      // Test 2: NB=4 decrypt.
      tick();
      a_valid = 1'b1; a_enc = 1'b0; a_data = FIPS_OUT;
      tick();
      a_valid = 1'b0;
      @(negedge clk);
      check("t2_valid", a_ovalid, 1);
      check("t2_data", a_odata, FIPS_IN);

      // Test 3: NB=8 encrypt of 00..1f, then decrypt back; LATENCY=3.
      tick();
      b_iready = 1'b1; b_valid = 1'b1; b_enc = 1'b1; b_data = asc8;
      tick();
      b_valid = 1'b0;
      @(negedge clk);
      check("t3_early_1", b_ovalid, 0);
      tick();
      @(negedge clk);
      check("t3_early_2", b_ovalid, 0);
      tick();
      @(negedge clk);
      check("t3_valid", b_ovalid, 1);
      check("t3_col0", b_odata[255 -: 32], 32'h00050e13);
      r = b_odata;
      tick();
      b_valid = 1'b1; b_enc = 1'b0; b_data = r;
      tick();
      b_valid = 1'b0;
      repeat (2) tick();
      @(negedge clk);
      check("t3_roundtrip_valid", b_ovalid, 1);
      check("t3_roundtrip", b_odata, asc8);

      // Test 4: random valid / ready stream on both instances.
      base_in = b_in_cnt;
      cycles  = 0;
      while (((b_in_cnt - base_in) < 24 || a_in_cnt < 40) && cycles < 3000) begin
         tick();
         cycles++;
         a_valid  = 1'($urandom_range(0, 1));
         a_enc    = 1'($urandom_range(0, 1));
         a_data   = W_A'(rand256());
         a_iready = 1'($urandom_range(0, 1));
         b_valid  = 1'($urandom_range(0, 1));
         b_enc    = 1'($urandom_range(0, 1));
         b_data   = rand256();
         b_iready = 1'($urandom_range(0, 1));
      end
      if (cycles >= 3000) fail_now("t4_stream_budget", "input budget expired");
      tick();
      a_valid = 1'b0; b_valid = 1'b0; a_iready = 1'b1; b_iready = 1'b1;
      cycles = 0;
      while ((q_a.size() != 0 || q_b.size() != 0) && cycles < 50) begin
         tick();
         cycles++;
      end
      @(negedge clk);
      check("t4_a_drained", q_a.size(), 0);
      check("t4_b_drained", q_b.size(), 0);
      check("t4_a_count", a_out_cnt, a_in_cnt);
      check("t4_b_count", b_out_cnt, b_in_cnt);
      check("t4_a_err", a_err, 0);
      check("t4_b_err", b_err, 0);

      // Test 5: reset with three words in flight in B.
      tick();
      b_iready = 1'b0;
      base_in  = b_in_cnt;
      b_valid  = 1'b1;
      repeat (3) begin
         b_data = rand256();
         b_enc  = 1'($urandom_range(0, 1));
         tick();
      end
      check("t5_accepted", b_in_cnt - base_in, 3);
      check("t5_inflight", b_ovalid, 1);
      b_valid = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("t5_valid_after_rst", b_ovalid, 0);
      check("t5_ready_after_rst", b_oready, 1);
      b_iready = 1'b1;
      base_out = b_out_cnt;
      repeat (8) tick();
      check("t5_nothing_emitted", b_out_cnt - base_out, 0);
      check("t5_still_idle", b_ovalid, 0);

`ifdef SHIFTROW_SELFCHECK_EN
      // Test 6: self-check flag, clean pass first, then a forced bit flip.
      tick();
      a_iready = 1'b0; a_valid = 1'b1; a_enc = 1'b1; a_data = FIPS_IN;
      tick();
      a_valid = 1'b0;
      repeat (3) begin
         @(negedge clk);
         check("t6_clean_err", a_err, 0);
      end
      tick();
      a_iready = 1'b1;
      tick();
      a_iready = 1'b0;
      a_valid = 1'b1; a_data = FIPS_IN;
      tick();
      a_valid  = 1'b0;
      a_chk_en = 1'b0;
      force dut_a.stage_data = FIPS_OUT ^ 128'h1;
      @(negedge clk);
      check("t6_err_before_edge", a_err, 0);
      tick();
      @(negedge clk);
      check("t6_err_set", a_err, 1);
      release dut_a.stage_data;
      tick();
      a_iready = 1'b1;
      tick();
      a_iready = 1'b0;
      repeat (3) tick();
      check("t6_err_sticky", a_err, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("t6_err_cleared", a_err, 0);
      a_chk_en = 1'b1;
`endif

      repeat (2) tick();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
